popcount_pipe: RTL and testbench
================================

Name: popcount_pipe

Overview:
- Parametrised, fully pipelined bit population counter. It is the successor to the fixed-width 4-bit-leaf counter.
- Adds arbitrary WIDTH (no truncation), a configurable leaf width, configurable adder-tree levels per register stage, and a per-word ones/zeros count mode.
- Adds valid/ready backpressure so the block can sit directly in a streaming datapath ahead of statistics or packet-classification logic.

Parameters:
- WIDTH, 32, input word width in bits; any value >= 1.
- LEAF_W, 4, bits counted combinationally per leaf; 1..8.
- LEVELS_PER_STAGE, 1, adder-tree levels between pipeline registers; >= 1.

Ports:
- clk_i  in  1  clock.
- srst_i  in  1  reset; asynchronous, active-high.
- data_i  in  WIDTH  word to count.
- mode_i  in  1  0 = count ones, 1 = count zeros; sampled with data_i.
- data_val_i  in  1  input valid.
- data_ready_o  out  1  input ready.
- data_o  out  $clog2(WIDTH+1)  population count.
- data_val_o  out  1  output valid.
- ready_i  in  1  downstream ready.

Behaviour:
- Derived constants:
  - NUM_LEAVES = ceil(WIDTH/LEAF_W).
  - TREE_LEVELS = $clog2(NUM_LEAVES), which is 0 when NUM_LEAVES = 1.
  - LAT = 1 + ceil(TREE_LEVELS/LEVELS_PER_STAGE).
- Input transfer occurs when data_val_i && data_ready_o. Output transfer occurs when data_val_o && ready_i.
- Datapath:
  - The input is zero-extended to NUM_LEAVES*LEAF_W bits.
  - In zeros mode only the WIDTH real bits are inverted. Padding bits never count.
  - Each leaf produces a $clog2(LEAF_W+1)-bit count.
  - Leaves are summed by a balanced binary tree. Each level widens the sum by 1 bit. An odd element at a level passes through unchanged.
  - The final sum is exactly $clog2(WIDTH+1) bits with no overflow; max value is WIDTH.
- Stage 0 registers the leaf counts together with the valid bit. A register follows every LEVELS_PER_STAGE tree levels. The last stage drives data_o and data_val_o directly.
- Latency is exactly LAT cycles from input transfer to data_val_o, with no stall.
- Throughput is one word per cycle while ready_i = 1.
- Backpressure:
  - stall = data_val_o && !ready_i.
  - data_ready_o = !stall (combinational from ready_i and the output valid register).
  - On stall, every pipeline stage holds its data and valid bits. No bubble is squeezed out, and no word is dropped or duplicated.
- A bubble (data_val_i = 0 on an accepted cycle) propagates as a stage with valid = 0. Data registers in a bubble stage may hold stale values.
- data_o is don't-care while data_val_o = 0. The bench checks it only on valid.
- Reset:
  - Asynchronous assert clears all stage valid bits, data_val_o and data_o to 0.
  - data_ready_o = 1 on the first cycle after deassert.
  - Reset mid-stream discards all in-flight words. No output appears until LAT cycles after the next accepted input.
- mode_i is per word. Mixed modes in consecutive cycles each produce the correct count for their own word.
- When WIDTH <= LEAF_W, there is no tree and LAT = 1.

Optional Feature:
- Macro: POPCOUNT_PIPE_TAG_EN.
- When defined:
  - Adds parameter TAG_W (default 8) and ports tag_i (in, TAG_W) and tag_o (out, TAG_W).
  - The tag is captured on input transfer and travels with the word through every stage, obeying the same stall rules.
  - tag_o resets to 0 and is valid with data_val_o.
- When undefined: no tag ports or registers exist, and behaviour is otherwise identical.

Decomposition:
- Package popcount_pkg holds:
  - functions num_leaves(width, leaf_w), tree_levels(n) and pipe_latency(width, leaf_w, lps);
  - localparam helpers for leaf and output widths.
- Both RTL and bench derive LAT from pipe_latency.
- Sub-module popcount_leaf (parameter LEAF_W) is a purely combinational leaf counter and is instantiated NUM_LEAVES times.
- The tree and pipeline registers live in a generate loop in popcount_pipe.

Test Plan:
- Defaults (LAT = 4), data_i = 32'hFFFF_FFFF, mode 0 → data_o = 32 with data_val_o exactly 4 cycles after transfer.
- Back-to-back 32'hF0F0_0001 (mode 0), 32'h0 (mode 1), 32'h8000_0000 (mode 0) → outputs 9, 32, 1 on three consecutive cycles.
- WIDTH = 7, LEAF_W = 4, data_i = 7'h0, mode 1 → data_o = 7 (padding not counted). data_i = 7'h7F, mode 0 → 7. LAT = 2.
- Stream of 10 random words with ready_i held low for 3 cycles mid-stream → data_ready_o low during stall; outputs match the reference model in order with no loss or duplication; data_o stable while stalled.
- srst_i asserted asynchronously with 3 words in flight → data_val_o drops immediately; no stale word is emitted after release; next word's result appears LAT cycles after its transfer.
- With POPCOUNT_PIPE_TAG_EN, tags 1..8 on 8 words with random ready_i → each tag_o matches its own word's count.

Source files
------------

// File: rtl/popcount_pkg.sv
// Shared sizing helpers for the pipelined population counter; both the RTL and
// the bench derive pipeline depth from pipe_latency().
package popcount_pkg;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_LEAF_W = 4;

  function automatic int num_leaves(input int width, input int leaf_w);
    return (width + leaf_w - 1) / leaf_w;
  endfunction

  function automatic int tree_levels(input int n);
    return (n <= 1) ? 0 : $clog2(n);
  endfunction

  function automatic int pipe_latency(input int width, input int leaf_w, input int lps);
    int tl;
    tl = tree_levels(num_leaves(width, leaf_w));
    return 1 + (tl + lps - 1) / lps;
  endfunction

  // Number of live partial sums after lvl halvings of n leaves.
  function automatic int level_size(input int n, input int lvl);
    int m;
    m = n;
    for (int i = 0; i < lvl; i++) m = (m + 1) / 2;
    return m;
  endfunction

  function automatic int leaf_cnt_w(input int leaf_w);
    return $clog2(leaf_w + 1);
  endfunction

  function automatic int count_w(input int width);
    return $clog2(width + 1);
  endfunction

  localparam int DEF_LEAF_CNT_W = leaf_cnt_w(DEF_LEAF_W);
  localparam int DEF_COUNT_W    = count_w(DEF_WIDTH);

endpackage

// File: rtl/popcount_leaf.sv
// Combinational ones counter for one LEAF_W-bit slice of the input word.
module popcount_leaf
  import popcount_pkg::*;
#(
  parameter int LEAF_W = 4
) (
  input  logic [LEAF_W-1:0]             bits_i,
  output logic [leaf_cnt_w(LEAF_W)-1:0] cnt_o
);

  localparam int CW = leaf_cnt_w(LEAF_W);

  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < LEAF_W; i++) cnt_o = cnt_o + CW'(bits_i[i]);
  end

endmodule

// File: rtl/popcount_pipe.sv
// Pipelined population counter: leaf counters feed a balanced adder tree with a
// register every LEVELS_PER_STAGE levels. POPCOUNT_PIPE_TAG_EN adds a sideband tag.
module popcount_pipe
  import popcount_pkg::*;
#(
  parameter int WIDTH            = 32,
  parameter int LEAF_W           = 4,
  parameter int LEVELS_PER_STAGE = 1
`ifdef POPCOUNT_PIPE_TAG_EN
  , parameter int TAG_W          = 8
`endif
) (
  input  logic                       clk_i,
  input  logic                       srst_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       mode_i,
  input  logic                       data_val_i,
  output logic                       data_ready_o,
  output logic [$clog2(WIDTH+1)-1:0] data_o,
  output logic                       data_val_o,
  input  logic                       ready_i
`ifdef POPCOUNT_PIPE_TAG_EN
  , input  logic [TAG_W-1:0]         tag_i,
  output logic [TAG_W-1:0]           tag_o
`endif
);

  localparam int NL    = num_leaves(WIDTH, LEAF_W);
  localparam int TL    = tree_levels(NL);
  localparam int LC_W  = leaf_cnt_w(LEAF_W);
  localparam int OUT_W = count_w(WIDTH);
  localparam int PAD_W = NL * LEAF_W;

  logic             stall;
  logic [PAD_W-1:0] word_ext;
  logic [LC_W-1:0]  leaf_cnt [NL];

  // Padding stays zero in both modes so it never contributes to the count.
  always_comb begin
    word_ext              = '0;
    word_ext[WIDTH-1:0]   = mode_i ? ~data_i : data_i;
  end

  for (genvar i = 0; i < NL; i++) begin : leaf_g
    popcount_leaf #(.LEAF_W(LEAF_W)) u_leaf (
      .bits_i (word_ext[i*LEAF_W +: LEAF_W]),
      .cnt_o  (leaf_cnt[i])
    );
  end

  // Partial sums are bounded by WIDTH, so every level is carried at OUT_W bits.
  for (genvar l = 0; l <= TL; l++) begin : lvl_g
    logic [OUT_W-1:0] sum_d [NL+1];
    logic [OUT_W-1:0] sum_o [NL+1];
    logic             vld_d;
    logic             vld_o;
`ifdef POPCOUNT_PIPE_TAG_EN
    logic [TAG_W-1:0] tag_d;
    logic [TAG_W-1:0] tag_o;
`endif

    if (l == 0) begin : src_g
      always_comb begin
        vld_d = data_val_i;
        for (int i = 0; i <= NL; i++) sum_d[i] = '0;
        for (int i = 0; i < NL; i++) sum_d[i] = OUT_W'(leaf_cnt[i]);
      end
`ifdef POPCOUNT_PIPE_TAG_EN
      assign tag_d = tag_i;
`endif
    end else begin : src_g
      localparam int NPREV = level_size(NL, l - 1);
      localparam int NCUR  = level_size(NL, l);
      always_comb begin
        vld_d = lvl_g[l-1].vld_o;
        for (int i = 0; i <= NL; i++) sum_d[i] = '0;
        for (int i = 0; i < NCUR; i++) begin
          if (2*i + 1 < NPREV) sum_d[i] = lvl_g[l-1].sum_o[2*i] + lvl_g[l-1].sum_o[2*i+1];
          else                 sum_d[i] = lvl_g[l-1].sum_o[2*i];
        end
      end
`ifdef POPCOUNT_PIPE_TAG_EN
      assign tag_d = lvl_g[l-1].tag_o;
`endif
    end

    if (l == 0 || l == TL || (l % LEVELS_PER_STAGE) == 0) begin : reg_g
      logic [OUT_W-1:0] sum_q [NL+1];
      logic             vld_q;
`ifdef POPCOUNT_PIPE_TAG_EN
      logic [TAG_W-1:0] tag_q;
`endif
      always_ff @(posedge clk_i or posedge srst_i) begin
        if (srst_i) begin
          vld_q <= 1'b0;
          sum_q <= '{default: '0};
`ifdef POPCOUNT_PIPE_TAG_EN
          tag_q <= '0;
`endif
        end else if (!stall) begin
          vld_q <= vld_d;
          sum_q <= sum_d;
`ifdef POPCOUNT_PIPE_TAG_EN
          tag_q <= tag_d;
`endif
        end
      end
      assign vld_o = vld_q;
      assign sum_o = sum_q;
`ifdef POPCOUNT_PIPE_TAG_EN
      assign tag_o = tag_q;
`endif
    end else begin : comb_g
      assign vld_o = vld_d;
      assign sum_o = sum_d;
`ifdef POPCOUNT_PIPE_TAG_EN
      assign tag_o = tag_d;
`endif
    end
  end

  assign stall        = lvl_g[TL].vld_o && !ready_i;
  assign data_ready_o = !stall;
  assign data_val_o   = lvl_g[TL].vld_o;
  assign data_o       = lvl_g[TL].sum_o[0];
`ifdef POPCOUNT_PIPE_TAG_EN
  assign tag_o        = lvl_g[TL].tag_o;
`endif

endmodule

// File: tb/tb_popcount_pipe.sv
// Bench for popcount_pipe: a 32-bit default instance and a 7-bit instance run
// side by side against a slot-queue reference model; tag checks when POPCOUNT_PIPE_TAG_EN.
module tb_popcount_pipe;
  import popcount_pkg::*;

  localparam int LAT32 = pipe_latency(32, 4, 1);
  localparam int LAT7  = pipe_latency(7, 4, 1);

  logic clk_i = 1'b0;
  logic srst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  logic [31:0] d32;
  logic        m32, v32, r32, rdyo32, valo32;
  logic [5:0]  q32;
  logic [6:0]  d7;
  logic        m7, v7, r7, rdyo7, valo7;
  logic [2:0]  q7;
`ifdef POPCOUNT_PIPE_TAG_EN
  logic [7:0]  t32_i, t32_o, t7_i, t7_o;
`endif

  popcount_pipe u32 (
    .clk_i(clk_i), .srst_i(srst_i), .data_i(d32), .mode_i(m32), .data_val_i(v32),
    .data_ready_o(rdyo32), .data_o(q32), .data_val_o(valo32), .ready_i(r32)
`ifdef POPCOUNT_PIPE_TAG_EN
    , .tag_i(t32_i), .tag_o(t32_o)
`endif
  );

  popcount_pipe #(.WIDTH(7), .LEAF_W(4), .LEVELS_PER_STAGE(1)) u7 (
    .clk_i(clk_i), .srst_i(srst_i), .data_i(d7), .mode_i(m7), .data_val_i(v7),
    .data_ready_o(rdyo7), .data_o(q7), .data_val_o(valo7), .ready_i(r7)
`ifdef POPCOUNT_PIPE_TAG_EN
    , .tag_i(t7_i), .tag_o(t7_o)
`endif
  );

  int total = 0;
  int bad   = 0;

  int          lat_u [2] = '{LAT32, LAT7};
  int          wid_u [2] = '{32, 7};
  logic        in_v [2], in_m [2], in_r [2];
  logic [31:0] in_d [2];
  logic [7:0]  in_t [2];
  logic        acc  [2];
  logic        mv   [2][8];
  logic [5:0]  md   [2][8];
  logic [7:0]  mt   [2][8];
  logic [5:0]  oq0[$], oq1[$];
  logic [7:0]  ot0[$];

  logic [31:0] words [10];
  logic        modes [10];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Count of bits among the low w that differ from the mode bit.
  function automatic logic [5:0] ref_count(input logic [31:0] d, input logic m, input int w);
    int c;
    c = 0;
    for (int b = 0; b < w; b++) if (d[b] != m) c++;
    return 6'(c);
  endfunction

  task automatic drive();
    v32 = in_v[0]; d32 = in_d[0]; m32 = in_m[0]; r32 = in_r[0];
    v7  = in_v[1]; d7  = in_d[1][6:0]; m7 = in_m[1]; r7 = in_r[1];
`ifdef POPCOUNT_PIPE_TAG_EN
    t32_i = in_t[0]; t7_i = in_t[1];
`endif
  endtask

  task automatic idle();
    for (int u = 0; u < 2; u++) begin
      in_v[u] = 1'b0; in_m[u] = 1'b0; in_r[u] = 1'b1; in_d[u] = '0; in_t[u] = '0;
    end
  endtask

  task automatic clear_model();
    for (int u = 0; u < 2; u++)
      for (int k = 0; k < 8; k++) begin
        mv[u][k] = 1'b0; md[u][k] = '0; mt[u][k] = '0;
      end
  endtask

  // One clock: starts and ends just after a falling edge.
  task automatic cyc();
    logic stall [2];
    logic ov;
    drive();
    #1;
    for (int u = 0; u < 2; u++) begin
      stall[u] = mv[u][lat_u[u]-1] && !in_r[u];
      acc[u]   = in_v[u] && !stall[u];
      chk($sformatf("ready_w%0d", wid_u[u]), (u == 0) ? 32'(rdyo32) : 32'(rdyo7), 32'(!stall[u]));
    end
    @(posedge clk_i);
    for (int u = 0; u < 2; u++) begin
      if (!stall[u]) begin
        for (int k = lat_u[u] - 1; k > 0; k--) begin
          mv[u][k] = mv[u][k-1]; md[u][k] = md[u][k-1]; mt[u][k] = mt[u][k-1];
        end
        mv[u][0] = in_v[u];
        md[u][0] = ref_count(in_d[u], in_m[u], wid_u[u]);
        mt[u][0] = in_t[u];
      end
    end
    @(negedge clk_i);
    for (int u = 0; u < 2; u++) begin
      ov = mv[u][lat_u[u]-1];
      chk($sformatf("val_w%0d", wid_u[u]), (u == 0) ? 32'(valo32) : 32'(valo7), 32'(ov));
      if (ov) begin
        chk($sformatf("data_w%0d", wid_u[u]), (u == 0) ? 32'(q32) : 32'(q7), 32'(md[u][lat_u[u]-1]));
`ifdef POPCOUNT_PIPE_TAG_EN
        chk($sformatf("tag_w%0d", wid_u[u]), (u == 0) ? 32'(t32_o) : 32'(t7_o), 32'(mt[u][lat_u[u]-1]));
`endif
      end
    end
    if (valo32 && r32) begin
      oq0.push_back(q32);
`ifdef POPCOUNT_PIPE_TAG_EN
      ot0.push_back(t32_o);
`endif
    end
    if (valo7 && r7) oq1.push_back({3'b0, q7});
  endtask

  task automatic drain();
    idle();
    repeat (10) cyc();
  endtask

  task automatic chk_reset_state();
    chk("rst_val32", 32'(valo32), 0);
    chk("rst_data32", 32'(q32), 0);
    chk("rst_ready32", 32'(rdyo32), 1);
    chk("rst_val7", 32'(valo7), 0);
    chk("rst_data7", 32'(q7), 0);
`ifdef POPCOUNT_PIPE_TAG_EN
    chk("rst_tag32", 32'(t32_o), 0);
`endif
  endtask

  task automatic push32(input logic [31:0] d, input logic m);
    in_v[0] = 1'b1; in_d[0] = d; in_m[0] = m; cyc();
  endtask

  initial begin
    int idx, cnum;
    idle();
    drive();
    clear_model();
    #2;
    chk_reset_state();
    @(negedge clk_i);
    srst_i = 1'b0;

    // Single all-ones word, exact latency from the model.
    push32(32'hFFFF_FFFF, 1'b0);
    drain();
    chk("ones_count", 32'(oq0.size()), 1);
    if (oq0.size() == 1) chk("ones_value", 32'(oq0[0]), 32);
    oq0.delete();

    // Back-to-back mixed modes.
    push32(32'hF0F0_0001, 1'b0);
    push32(32'h0000_0000, 1'b1);
    push32(32'h8000_0000, 1'b0);
    drain();
    chk("b2b_count", 32'(oq0.size()), 3);
    if (oq0.size() == 3) begin
      chk("b2b_0", 32'(oq0[0]), 9);
      chk("b2b_1", 32'(oq0[1]), 32);
      chk("b2b_2", 32'(oq0[2]), 1);
    end
    oq0.delete();

    // Narrow instance: padding must not count as zeros.
    in_v[1] = 1'b1; in_d[1] = 32'h0;  in_m[1] = 1'b1; cyc();
    in_v[1] = 1'b1; in_d[1] = 32'h7F; in_m[1] = 1'b0; cyc();
    in_v[1] = 1'b1; in_d[1] = 32'h55; in_m[1] = 1'b1; cyc();
    drain();
    chk("w7_count", 32'(oq1.size()), 3);
    if (oq1.size() == 3) begin
      chk("w7_zeros", 32'(oq1[0]), 7);
      chk("w7_ones", 32'(oq1[1]), 7);
      chk("w7_mixed", 32'(oq1[2]), 3);
    end
    oq1.delete();

    // Random stream with a three-cycle downstream stall.
    for (int i = 0; i < 10; i++) begin
      words[i] = $urandom;
      modes[i] = 1'($urandom_range(0, 1));
    end
    idx = 0; cnum = 0;
    while (idx < 10 && cnum < 100) begin
      in_v[0] = 1'b1; in_d[0] = words[idx]; in_m[0] = modes[idx];
      in_r[0] = !(cnum >= 4 && cnum < 7);
      cyc();
      if (cnum >= 4 && cnum < 7) chk("stall_ready_low", 32'(rdyo32), 0);
      if (acc[0]) idx++;
      cnum++;
    end
    chk("stream_accepted", 32'(idx), 10);
    drain();
    chk("stream_count", 32'(oq0.size()), 10);
    for (int i = 0; i < 10 && i < oq0.size(); i++)
      chk($sformatf("stream_%0d", i), 32'(oq0[i]), 32'(ref_count(words[i], modes[i], 32)));
    oq0.delete();

    // Random traffic on both instances with random backpressure.
    for (int n = 0; n < 60; n++) begin
      for (int u = 0; u < 2; u++) begin
        in_v[u] = 1'($urandom_range(0, 1));
        in_d[u] = $urandom;
        in_m[u] = 1'($urandom_range(0, 1));
        in_r[u] = ($urandom_range(0, 3) != 0);
        in_t[u] = 8'($urandom);
      end
      cyc();
    end
    drain();
    oq0.delete(); oq1.delete(); ot0.delete();

    // Asynchronous reset with words in flight.
    for (int i = 0; i < 4; i++) push32($urandom, 1'($urandom_range(0, 1)));
    idle();
    drive();
    chk("pre_reset_val", 32'(valo32), 1);
    #2 srst_i = 1'b1;
    #1;
    chk_reset_state();
    clear_model();
    @(posedge clk_i);
    @(negedge clk_i);
    srst_i = 1'b0;
    oq0.delete();
    repeat (3) cyc();
    push32(32'h0000_00FF, 1'b0);
    drain();
    chk("post_reset_count", 32'(oq0.size()), 1);
    if (oq0.size() == 1) chk("post_reset_value", 32'(oq0[0]), 8);
    oq0.delete();

`ifdef POPCOUNT_PIPE_TAG_EN
    // Tags 1..8 under random backpressure.
    ot0.delete();
    for (int i = 0; i < 8; i++) begin
      words[i] = $urandom;
      modes[i] = 1'($urandom_range(0, 1));
    end
    idx = 0; cnum = 0;
    while (idx < 8 && cnum < 200) begin
      in_v[0] = 1'b1; in_d[0] = words[idx]; in_m[0] = modes[idx];
      in_t[0] = 8'(idx + 1);
      in_r[0] = 1'($urandom_range(0, 1));
      cyc();
      if (acc[0]) idx++;
      cnum++;
    end
    chk("tag_accepted", 32'(idx), 8);
    drain();
    chk("tag_count", 32'(ot0.size()), 8);
    for (int i = 0; i < 8 && i < ot0.size(); i++) begin
      chk($sformatf("tag_%0d", i), 32'(ot0[i]), 32'(i + 1));
      chk($sformatf("tag_data_%0d", i), 32'(oq0[i]), 32'(ref_count(words[i], modes[i], 32)));
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
